// File: rtl/sha256_pkg.sv
// Shared types, constants and round functions for the streaming SHA-256 core.
// Word 0 of every packed word array sits in the most-significant slot.
package sha256_pkg;

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eBusy  = 2'd1,
        eFinal = 2'd2,
        eDone  = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    typedef logic [0:7][31:0]  hash_t;
    typedef logic [0:15][31:0] window_t;

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One purely combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] k_t,
    input  logic [31:0] w_t,
    output work_t       nxt
);

    logic [31:0] t1_s;
    logic [31:0] t2_s;

    // Round function: two temporaries, then rotate the working variables
    always_comb begin
        t1_s  = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k_t + w_t;
        t2_s  = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
        nxt.a = t1_s + t2_s;
        nxt.b = cur.a;
        nxt.c = cur.b;
        nxt.d = cur.c;
        nxt.e = cur.d + t1_s;
        nxt.f = cur.e;
        nxt.g = cur.f;
        nxt.h = cur.g;
    end

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 engine: takes pre-padded 512-bit blocks, chains the hash
// state across a message and returns the digest with a valid/yumi handshake.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int ROUND_CTR_W      = $clog2(64 / ROUNDS_PER_CYCLE) + 1
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         en_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [511:0] block_i,
    input  logic         first_i,
    input  logic         last_i,
    output logic         v_o,
    input  logic         yumi_i,
    output logic [255:0] digest_o
);

    localparam int R     = ROUNDS_PER_CYCLE;
    localparam int STEPS = 64 / R;
    localparam logic [ROUND_CTR_W-1:0] LAST_STEP = ROUND_CTR_W'(STEPS - 1);

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    if (ROUND_CTR_W != $clog2(64 / R) + 1) begin : g_bad_ctr_w
        $error("ROUND_CTR_W is derived and must not be overridden");
    end

    state_e                 state_r;
    state_e                 state_next_s;
    logic [ROUND_CTR_W-1:0] ctr_r;
    window_t                window_r;
    window_t                window_next_s;
    work_t                  work_r;
    work_t                  start_work_s;
    work_t                  round_out_s;
    hash_t                  hash_r;
    hash_t                  work_hash_s;
    hash_t                  hash_sum_s;
    logic                   chain_valid_r;
    logic                   last_r;
    logic                   use_iv_s;
    logic                   v_r;
    logic [255:0]           digest_r;

    // Extends the schedule by R words and slides the window past the consumed ones
    function automatic window_t expand(input window_t win);
        logic [31:0] ext [0:23];
        window_t     res;
        for (int i = 0; i < 16; i++) begin
            ext[i] = win[i];
        end
        for (int i = 16; i < 24; i++) begin
            ext[i] = small_sigma1(ext[i-2]) + ext[i-7] + small_sigma0(ext[i-15]) + ext[i-16];
        end
        for (int k = 0; k < 16; k++) begin
            res[k] = ext[k+R];
        end
        return res;
    endfunction

    assign ready_o  = (state_r == eIdle) & en_i;
    assign v_o      = v_r;
    assign digest_o = digest_r;

    // R chained rounds; round j of a step uses window word j and K[ctr*R+j]
    for (genvar j = 0; j < R; j++) begin : g_round
        work_t       in_s;
        work_t       out_s;
        logic [5:0]  kidx_s;
        if (j == 0) begin : g_head
            assign in_s = work_r;
        end else begin : g_tail
            assign in_s = g_round[j-1].out_s;
        end
        assign kidx_s = 6'(32'(ctr_r) * R + j);
        sha256_round u_round (
            .cur (in_s),
            .k_t (K_TABLE[kidx_s]),
            .w_t (window_r[j]),
            .nxt (out_s)
        );
    end
    assign round_out_s = g_round[R-1].out_s;

    // Datapath helpers: IV/chain selection, schedule update, final feed-forward sum
    always_comb begin
        use_iv_s      = first_i | ~chain_valid_r;
        start_work_s  = use_iv_s ? work_t'(IV) : work_t'(hash_r);
        window_next_s = expand(window_r);
        work_hash_s   = hash_t'(work_r);
        for (int i = 0; i < 8; i++) begin
            hash_sum_s[i] = hash_r[i] + work_hash_s[i];
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= eIdle;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a low enable holds the current state
    always_comb begin
        state_next_s = state_r;
        if (!en_i) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                eIdle: begin
                    if (v_i) state_next_s = eBusy;
                    else     state_next_s = eIdle;
                end
                eBusy: begin
                    if (ctr_r == LAST_STEP) state_next_s = eFinal;
                    else                    state_next_s = eBusy;
                end
                eFinal: begin
                    if (last_r) state_next_s = eDone;
                    else        state_next_s = eIdle;
                end
                eDone: begin
                    if (yumi_i) state_next_s = eIdle;
                    else        state_next_s = eDone;
                end
                default: state_next_s = eIdle;
            endcase
        end
    end

    // Datapath registers: schedule window, working vars, chained hash and digest
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctr_r         <= '0;
            window_r      <= '0;
            work_r        <= '0;
            hash_r        <= IV;
            chain_valid_r <= 1'b0;
            last_r        <= 1'b0;
            v_r           <= 1'b0;
            digest_r      <= 256'd0;
        end else if (en_i) begin
            case (state_r)
                eIdle: begin
                    if (v_i) begin
                        window_r <= window_t'(block_i);
                        work_r   <= start_work_s;
                        if (use_iv_s) hash_r <= IV;
                        last_r   <= last_i;
                        ctr_r    <= '0;
                    end
                end
                eBusy: begin
                    work_r   <= round_out_s;
                    window_r <= window_next_s;
                    ctr_r    <= ctr_r + ROUND_CTR_W'(1);
                end
                eFinal: begin
                    hash_r        <= hash_sum_s;
                    // A finished message must not seed the next one
                    chain_valid_r <= ~last_r;
                    if (last_r) begin
                        digest_r <= hash_sum_s;
                        v_r      <= 1'b1;
                    end
                end
                eDone: begin
                    if (yumi_i) v_r <= 1'b0;
                end
                default: begin
                    v_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Scoreboard bench for sha256_stream_core with R=1, R=4 and R=8 instances.
module tb_sha256_stream_core;

    localparam int NDUT = 3;

    localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] B1_BLK  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] B2_BLK  = {{15{32'h00000000}}, 32'h000001c0};
    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_448 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        int           dut;
        logic [255:0] digest;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en    [NDUT];
    logic         v_in  [NDUT];
    logic         first [NDUT];
    logic         last  [NDUT];
    logic         yumi  [NDUT];
    logic [511:0] blk   [NDUT];
    logic         ready [NDUT];
    logic         v_out [NDUT];
    logic [255:0] dig   [NDUT];

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int RPC = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        sha256_stream_core #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
            .clk_i     (clk),
            .reset_n_i (rst_n),
            .en_i      (en[g]),
            .v_i       (v_in[g]),
            .ready_o   (ready[g]),
            .block_i   (blk[g]),
            .first_i   (first[g]),
            .last_i    (last[g]),
            .v_o       (v_out[g]),
            .yumi_i    (yumi[g]),
            .digest_o  (dig[g])
        );
    end

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_d(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every digest handed over (v_o & yumi_i) is matched against the queue
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst_n && en[d] && v_out[d] && yumi[d]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_digest dut=%0d actual=%h expected=none", d, dig[d]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_i("digest_source", d, e.dut);
                    check_d("digest", dig[d], e.digest);
                end
            end
        end
    end

    // Offers one block; returns #1 after the accept edge
    task automatic send(input int d, input logic [511:0] b, input logic f, input logic l,
                        input logic [255:0] exp_dig);
        int n = 0;
        while (!ready[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_b("ready_before_send", ready[d], 1'b1);
        blk[d]   = b;
        first[d] = f;
        last[d]  = l;
        v_in[d]  = 1'b1;
        if (l) exp_q.push_back('{dut: d, digest: exp_dig});
        @(posedge clk); #1;
        v_in[d]  = 1'b0;
        first[d] = 1'b0;
        last[d]  = 1'b0;
    endtask

    task automatic wait_valid(input int d, input int limit, output int cycles);
        cycles = 0;
        while (!v_out[d] && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic wait_ready(input int d, input int limit, output int cycles);
        cycles = 0;
        while (!ready[d] && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            en[d]    = 1'b1;
            v_in[d]  = 1'b0;
            first[d] = 1'b0;
            last[d]  = 1'b0;
            yumi[d]  = 1'b1;
            blk[d]   = 512'd0;
        end
        en[0] = 1'b0;
        #1;
        // Reset state
        check_b("rst_ready_en_low", ready[0], 1'b0);
        for (int d = 0; d < NDUT; d++) begin
            check_b("rst_v_o", v_out[d], 1'b0);
            check_d("rst_digest", dig[d], 256'd0);
        end
        check_b("rst_ready_en_high", ready[1], 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        en[0] = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < NDUT; d++) check_b("post_rst_ready", ready[d], 1'b1);

        // "abc" single block, R=1: v_o rises 65 edges after accept
        send(0, ABC_BLK, 1'b1, 1'b1, D_ABC);
        wait_valid(0, 200, cyc);
        check_i("latency_r1", cyc, 65);

        // Two-block NIST message, R=4: next accept possible on edge 18
        send(1, B1_BLK, 1'b1, 1'b0, 256'd0);
        wait_ready(1, 100, cyc);
        check_i("ready_again_r4", cyc + 1, 18);
        send(1, B2_BLK, 1'b0, 1'b1, D_448);
        wait_valid(1, 100, cyc);
        check_i("latency_r4", cyc, 17);

        // first_i mid-message discards the partial hash
        send(1, B1_BLK, 1'b1, 1'b0, 256'd0);
        send(1, ABC_BLK, 1'b1, 1'b1, D_ABC);
        wait_valid(1, 100, cyc);
        check_b("restart_valid", v_out[1], 1'b1);

        // Back-to-back "abc", R=8; the second has first_i=0 yet must start from IV
        send(2, ABC_BLK, 1'b1, 1'b1, D_ABC);
        wait_valid(2, 100, cyc);
        check_i("latency_r8", cyc, 9);
        send(2, ABC_BLK, 1'b0, 1'b1, D_ABC);
        wait_valid(2, 100, cyc);
        check_i("latency_r8_second", cyc, 9);

        // Backpressure: digest held while yumi_i low, v_i pulses ignored
        @(posedge clk); #1;
        yumi[2] = 1'b0;
        send(2, ABC_BLK, 1'b1, 1'b1, D_ABC);
        wait_valid(2, 100, cyc);
        check_b("bp_valid", v_out[2], 1'b1);
        for (int i = 0; i < 20; i++) begin
            check_b("bp_v_o_stable", v_out[2], 1'b1);
            check_d("bp_digest_stable", dig[2], D_ABC);
            check_b("bp_not_ready", ready[2], 1'b0);
            blk[2]   = 512'd0;
            first[2] = 1'b1;
            last[2]  = 1'b1;
            v_in[2]  = i[0];
            @(posedge clk); #1;
        end
        v_in[2]  = 1'b0;
        first[2] = 1'b0;
        last[2]  = 1'b0;
        yumi[2]  = 1'b1;
        @(posedge clk); #1;
        check_b("bp_released", v_out[2], 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check_b("bp_pulses_dropped", v_out[2], 1'b0);
        check_b("bp_idle", ready[2], 1'b1);

        // en_i low for 10 cycles mid-eBusy delays completion by exactly 10
        send(0, ABC_BLK, 1'b1, 1'b1, D_ABC);
        repeat (20) @(posedge clk);
        #1;
        en[0] = 1'b0;
        repeat (10) begin
            check_b("en_low_ready", ready[0], 1'b0);
            @(posedge clk); #1;
        end
        en[0] = 1'b1;
        wait_valid(0, 200, cyc);
        check_i("latency_en_gap", cyc + 30, 75);

        // Reset mid-eBusy
        send(1, ABC_BLK, 1'b1, 1'b1, D_ABC);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        #1;
        check_b("rst_busy_v_o", v_out[1], 1'b0);
        check_b("rst_busy_ready", ready[1], 1'b1);
        @(posedge clk); #1;

        // Reset during eDone drops v_o asynchronously
        yumi[1] = 1'b0;
        send(1, ABC_BLK, 1'b1, 1'b1, D_ABC);
        wait_valid(1, 100, cyc);
        check_b("done_valid", v_out[1], 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_b("rst_done_async_v_o", v_out[1], 1'b0);
        check_d("rst_done_digest", dig[1], 256'd0);
        rst_n = 1'b1;
        #1;
        check_b("rst_done_ready", ready[1], 1'b1);
        @(posedge clk); #1;
        yumi[1] = 1'b1;
        send(1, ABC_BLK, 1'b1, 1'b1, D_ABC);
        wait_valid(1, 100, cyc);
        check_i("latency_after_reset", cyc, 17);

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_i("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
